// File: rtl/core_pkg.sv
// core_pkg: shared core-wide widths and trace record types
package core_pkg;

    localparam int XLEN = 32;

    // Trace record leaving the core; kept as a struct so sideband fields can be added later.
    typedef struct packed {
        logic [XLEN-1:0] data;
    } wb_trace_t;

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: generic synchronous FIFO with a registered head and extra-MSB pointers
module trace_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_next;
    logic             do_push;
    logic             do_pop;
    logic             bypass;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_next = rd_ptr + PW'(do_pop);
    // The slot that becomes the head is being written this very edge, so forward the write data.
    assign bypass  = do_push && (wr_ptr[AW-1:0] == rd_next[AW-1:0]);

    // Storage array; pointers define which entries are meaningful, so no reset is needed.
    always_ff @(posedge clk)
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= wdata;

    // Pointers plus a head register preloaded with the entry at the next read pointer.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdata  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdata  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(do_push);
            rd_ptr <= rd_next;
            rdata  <= bypass ? wdata : mem[rd_next[AW-1:0]];
        end

endmodule

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: buffers retired write-back values with duplicate filtering and drop accounting
module wb_trace_buffer
    import core_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [XLEN-1:0]        wb_data_i,
    input  logic                   wb_valid_i,
    input  logic                   filter_dup_i,
    input  logic                   clear_i,
    output logic [XLEN-1:0]        m_data_o,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [$clog2(DEPTH):0] level_o,
    output logic [CNT_W-1:0]       drop_cnt_o,
    output logic                   overflow_o
);

    wb_trace_t       wr_item;
    wb_trace_t       rd_item;
    logic [XLEN-1:0] last_val;
    logic            last_valid;
    logic            full;
    logic            empty;
    logic            pop;
    logic            dup;
    logic            cand;
    logic            accept;
    logic            drop;

    assign pop          = m_valid_o && m_ready_i;
    assign dup          = filter_dup_i && last_valid && (wb_data_i == last_val);
    assign cand         = wb_valid_i && !dup;
    // A full FIFO still takes a value when the head leaves on the same edge.
    assign accept       = cand && (!full || pop);
    assign drop         = cand && !accept;
    assign wr_item.data = wb_data_i;
    assign m_valid_o    = !empty;
    assign m_data_o     = rd_item.data;

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(wb_trace_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_i),
        .push  (accept),
        .wdata (wr_item),
        .pop   (pop),
        .rdata (rd_item),
        .full  (full),
        .empty (empty),
        .level (level_o)
    );

    // Last accepted value for the duplicate filter, plus saturating drop count and sticky overflow.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            last_val   <= '0;
            last_valid <= 1'b0;
            drop_cnt_o <= '0;
            overflow_o <= 1'b0;
        end else if (clear_i) begin
            last_val   <= '0;
            last_valid <= 1'b0;
            drop_cnt_o <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (accept) begin
                last_val   <= wb_data_i;
                last_valid <= 1'b1;
            end
            if (drop) begin
                drop_cnt_o <= drop_cnt_o + CNT_W'(drop_cnt_o != '1);
                overflow_o <= 1'b1;
            end
        end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: directed and randomized checks of wb_trace_buffer against a queue model
module tb_wb_trace_buffer;

    localparam int DEPTH = 16;
    localparam int CNT_W = 4;
    localparam int MAXD  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] wb_data_i = '0;
    logic        wb_valid_i = 1'b0;
    logic        filter_dup_i = 1'b0;
    logic        clear_i = 1'b0;
    logic [31:0] m_data_o;
    logic        m_valid_o;
    logic        m_ready_i = 1'b0;
    logic [4:0]  level_o;
    logic [CNT_W-1:0] drop_cnt_o;
    logic        overflow_o;

    int ncmp = 0;
    int nerr = 0;

    logic [31:0] q[$];
    logic [31:0] lval = '0;
    bit          lv = 1'b0;
    int          drops = 0;
    bit          ovf = 1'b0;

    wb_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_data_i    (wb_data_i),
        .wb_valid_i   (wb_valid_i),
        .filter_dup_i (filter_dup_i),
        .clear_i      (clear_i),
        .m_data_o     (m_data_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .level_o      (level_o),
        .drop_cnt_o   (drop_cnt_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        lval  = '0;
        lv    = 1'b0;
        drops = 0;
        ovf   = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".valid"}, 32'(m_valid_o), 32'(q.size() != 0));
        chk({tag, ".level"}, 32'(level_o), 32'(q.size()));
        chk({tag, ".drop"}, 32'(drop_cnt_o), 32'(drops));
        chk({tag, ".ovf"}, 32'(overflow_o), 32'(ovf));
        if (q.size() != 0)
            chk({tag, ".data"}, m_data_o, q[0]);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".valid0"}, 32'(m_valid_o), 32'd0);
        chk({tag, ".level0"}, 32'(level_o), 32'd0);
        chk({tag, ".drop0"}, 32'(drop_cnt_o), 32'd0);
        chk({tag, ".ovf0"}, 32'(overflow_o), 32'd0);
        chk({tag, ".data0"}, m_data_o, 32'd0);
    endtask

    task automatic step(input string tag, input logic v, input logic [31:0] d,
                        input logic f, input logic r, input logic c);
        int sz;
        bit pop;
        bit cand;
        wb_valid_i   = v;
        wb_data_i    = d;
        filter_dup_i = f;
        m_ready_i    = r;
        clear_i      = c;
        @(posedge clk);
        sz   = q.size();
        pop  = r && sz != 0;
        cand = v && !(f && lv && d == lval);
        if (c)
            model_reset();
        else begin
            if (pop)
                void'(q.pop_front());
            if (cand && (sz < DEPTH || pop)) begin
                q.push_back(d);
                lval = d;
                lv   = 1'b1;
            end else if (cand) begin
                if (drops < MAXD)
                    drops++;
                ovf = 1'b1;
            end
        end
        #1;
        check_state(tag);
    endtask

    initial begin
        int rp;
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Simple stream with a ready consumer
        step("s11", 1, 32'h11, 0, 1, 0);
        chk("s11.out", m_data_o, 32'h11);
        step("s22", 1, 32'h22, 0, 1, 0);
        chk("s22.out", m_data_o, 32'h22);
        step("s33", 1, 32'h33, 0, 1, 0);
        chk("s33.out", m_data_o, 32'h33);
        chk("s33.lvl", 32'(level_o), 32'd1);
        step("sdrain", 0, 0, 0, 1, 0);

        // Fill past capacity, then push into a full FIFO while popping
        for (int i = 0; i < 18; i++)
            step("fill", 1, 32'(i), 0, 0, 0);
        chk("fill.lvl", 32'(level_o), 32'd16);
        chk("fill.drop", 32'(drop_cnt_o), 32'd2);
        chk("fill.ovf", 32'(overflow_o), 32'd1);
        step("fullpp", 1, 32'hAA, 0, 1, 0);
        chk("fullpp.lvl", 32'(level_o), 32'd16);
        chk("fullpp.drop", 32'(drop_cnt_o), 32'd2);
        for (int i = 0; i < 16; i++)
            step("drain", 0, 0, 0, 1, 0);

        // Duplicate filter on, then off
        step("dup5a", 1, 5, 1, 0, 0);
        step("dup5b", 1, 5, 1, 0, 0);
        step("dup7", 1, 7, 1, 0, 0);
        step("dup5c", 1, 5, 1, 0, 0);
        chk("dupon.lvl", 32'(level_o), 32'd3);
        for (int i = 0; i < 3; i++)
            step("dupdrain", 0, 0, 0, 1, 0);
        step("nd5a", 1, 5, 0, 0, 0);
        step("nd5b", 1, 5, 0, 0, 0);
        step("nd7", 1, 7, 0, 0, 0);
        step("nd5c", 1, 5, 0, 0, 0);
        chk("dupoff.lvl", 32'(level_o), 32'd4);
        chk("dupoff.drop", 32'(drop_cnt_o), 32'd2);
        for (int i = 0; i < 4; i++)
            step("nddrain", 0, 0, 0, 1, 0);

        // Clear wins over a simultaneous push and pop
        step("cl1", 1, 1, 0, 0, 0);
        step("cl2", 1, 2, 0, 0, 0);
        step("cl3", 1, 3, 0, 0, 0);
        step("cl5", 1, 5, 0, 0, 0);
        step("clr", 1, 5, 1, 1, 1);
        check_zero("clr");
        step("post5", 1, 5, 1, 0, 0);
        chk("post5.lvl", 32'(level_o), 32'd1);
        chk("post5.data", m_data_o, 32'd5);

        // Drop counter saturation
        for (int i = 0; i < 40; i++)
            step("sat", 1, 32'(100 + i), 0, 0, 0);
        chk("sat.drop", 32'(drop_cnt_o), 32'(MAXD));

        // Asynchronous reset between edges
        step("arclr", 0, 0, 0, 0, 1);
        for (int i = 0; i < 18; i++)
            step("arfill", 1, 32'(200 + i), 0, 0, 0);
        for (int i = 0; i < 8; i++)
            step("arpop", 0, 0, 0, 1, 0);
        chk("ar.lvl", 32'(level_o), 32'd8);
        chk("ar.ovf", 32'(overflow_o), 32'd1);
        m_ready_i = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_zero("arst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step("ar1", 1, 1, 0, 0, 0);
        chk("ar1.data", m_data_o, 32'd1);

        // Randomized traffic with a small value set so duplicates are frequent
        rp = 50;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0)
                rp = $urandom_range(0, 100);
            step("rand",
                 $urandom_range(0, 3) != 0,
                 32'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 99) < rp,
                 $urandom_range(0, 149) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Buffers retired write-back values leaving the core and streams them to an off-core consumer (debug UART bridge or testbench monitor) over a valid/ready interface. It sits directly downstream of the core's `wb_data_o` output and absorbs bursts from the single-issue pipeline. It can optionally suppress consecutive duplicate values, and it counts values lost to overflow.

## Interface
- `DEPTH`, 16: FIFO entries. Must be a power of two, ≥ 2.
- `CNT_W`, 16: width of the drop counter.
- `clk` in 1: core clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `wb_data_i` in 32: write-back value from the core.
- `wb_valid_i` in 1: `wb_data_i` is a retired value this cycle (one pulse per instruction).
- `filter_dup_i` in 1: when 1, drop a value equal to the last accepted value.
- `clear_i` in 1: synchronous flush of FIFO and statistics.
- `m_data_o` out 32: head-of-FIFO value.
- `m_valid_o` out 1: `m_data_o` is valid.
- `m_ready_i` in 1: consumer accepts the head this cycle.
- `level_o` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `drop_cnt_o` out CNT_W: values lost to overflow. Saturates at all-ones.
- `overflow_o` out 1: sticky flag, set on the first drop.

## Operation
- Reset values: all pointers 0, `level_o`=0, `m_valid_o`=0, `m_data_o`=0, `drop_cnt_o`=0, `overflow_o`=0, last-value register invalid.
- Pop: occurs when `m_valid_o && m_ready_i`. The read pointer increments and wraps modulo DEPTH.
- Candidate push: `wb_valid_i && !(filter_dup_i && last_valid && wb_data_i==last_val)`.
- A filtered value is neither stored nor counted as a drop.
- A candidate push is accepted if `level_o<DEPTH`, or if `level_o==DEPTH` and a pop occurs in the same cycle.
- Otherwise the push is a drop:
  - `drop_cnt_o` increments unless it is saturated.
  - `overflow_o` is set.
  - The last-value register is not updated.
- On every accepted push, `last_val` takes `wb_data_i` and `last_valid` is set to 1.
- Simultaneous push and pop leave `level_o` unchanged.
- When empty, a push is not passed through in the same cycle; `m_valid_o` rises the following cycle.
- `clear_i`=1 returns the block to its reset state on the next edge. It overrides any push, pop or drop in the same cycle.
- Pointers are $clog2(DEPTH)+1 bits wide:
  - Full when the MSBs differ and the remaining bits are equal.
  - Empty when the pointers are equal.
- While `m_valid_o`=1 and `m_ready_i`=0, `m_data_o` is stable.
- Asserting `rst` mid-stream discards all contents immediately (asynchronously). No partial state survives.

## Timing
- Push-to-output latency is 1 cycle. A value accepted at edge N is presented at `m_data_o` after edge N when the FIFO was empty.
- Throughput: one push and one pop per cycle.
- `level_o`, `drop_cnt_o` and `overflow_o` are registered and update on the edge that performs the event.
- `m_data_o` is read from storage at the read pointer, with a registered head. No combinational path from `wb_data_i` to `m_data_o`.
- `m_ready_i` may depend combinationally on `m_valid_o`. `m_valid_o` does not depend on `m_ready_i`.

## Structure
- Shared package `core_pkg`:
  - `XLEN`=32.
  - `wb_trace_t`, a struct holding `{data[XLEN-1:0]}` so that fields can be extended later.
- Sub-module `trace_fifo`:
  - Generic synchronous FIFO with parameters DEPTH and WIDTH.
  - Ports: push/pop, full/empty, level, sync clear.
- `wb_trace_buffer` contains the duplicate filter, overflow accounting and handshake glue around `trace_fifo`.

## Test plan
- **Simple stream.** Reset, then push 0x11, 0x22, 0x33 on consecutive cycles with `m_ready_i`=1 → `m_data_o` shows 0x11, 0x22, 0x33 on cycles 1, 2, 3 after each push; `level_o` never exceeds 1; `drop_cnt_o`=0.
- **Fill and overflow.** With `m_ready_i`=0, push 18 values 0..17 (DEPTH=16) → `level_o`=16, `drop_cnt_o`=2, `overflow_o`=1. Then drain → outputs 0..15 in order.
- **Simultaneous push/pop when full.** With the FIFO full, push 0xAA while `m_ready_i`=1 → accepted with no drop; `level_o` stays 16; 0xAA exits 16th after the current head.
- **Duplicate filter.** With `filter_dup_i`=1, push 5, 5, 7, 5 → outputs 5, 7, 5; `drop_cnt_o`=0. Repeat with `filter_dup_i`=0 → outputs 5, 5, 7, 5.
- **Clear priority.** Push 4 values, then assert `clear_i` in the same cycle as a push and a pop → next cycle `level_o`=0, `m_valid_o`=0, `drop_cnt_o`=0, `overflow_o`=0. The next push of 0x5 is not filtered.
- **Async reset mid-stream.** With 8 entries and `overflow_o`=1, drop `rst` low between clock edges → all outputs go to their reset values without waiting for a clock edge. After release, pushing 0x1 yields 0x1.
